// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder: one shared 4-bit BCD digit stage stepped LSD-first
// across DIGITS digits, between a valid/ready requester and a valid/ready consumer.
//
// state | meaning
// IDLE  | ready for a new operation; last result held on sum/cout/err
// RUN   | one digit added per cycle, carry rippled through r_carry
// DONE  | result valid, held until the consumer takes it
module bcd_serial_add_ctrl #(
   parameter int DIGITS = 4,
   parameter int CNT_W  = 3,
   localparam int W     = 4*DIGITS
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] sum,
   output logic         cout,
   output logic         err,
   output logic         busy
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [W-1:0]       r_a;
   logic [W-1:0]       r_b;
   logic [W-1:0]       r_sum;
   logic               r_carry;
   logic               r_cout;
   logic               r_err;
   logic [CNT_W-1:0]   r_idx;
   logic [3:0]         w_dig_a;
   logic [3:0]         w_dig_b;
   logic [4:0]         w_t;
   logic [3:0]         w_digit;
   logic               w_carry_nxt;
   logic               w_last;

   function automatic logic f_non_bcd(input logic [W-1:0] v);
      logic r;
      r = 1'b0;
      for (int d = 0; d < DIGITS; d++)
         if (v[4*d +: 4] > 4'd9) r = 1'b1;
      return r;
   endfunction

   assign w_last = (r_idx == CNT_W'(DIGITS-1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (in_valid)  w_state_nxt = S_RUN;
         S_RUN:   if (w_last)    w_state_nxt = S_DONE;
         S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
         default:                w_state_nxt = S_IDLE;
      endcase
   end

   assign in_ready  = (r_state == S_IDLE);
   assign busy      = (r_state == S_RUN);
   assign out_valid = (r_state == S_DONE);
   assign sum       = r_sum;
   assign cout      = r_cout;
   assign err       = r_err;

   // Shared digit stage: binary add, then +6 when the 5-bit sum passes 9.
   always_comb begin
      w_dig_a = 4'd0;
      w_dig_b = 4'd0;
      for (int d = 0; d < DIGITS; d++) begin
         if (r_idx == CNT_W'(d)) begin
            w_dig_a = r_a[4*d +: 4];
            w_dig_b = r_b[4*d +: 4];
         end
      end
      w_t = {1'b0, w_dig_a} + {1'b0, w_dig_b} + {4'd0, r_carry};
      if (w_t > 5'd9) begin
         w_digit     = w_t[3:0] + 4'd6;
         w_carry_nxt = 1'b1;
      end else begin
         w_digit     = w_t[3:0];
         w_carry_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_err   <= 1'b0;
         r_idx   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_carry <= cin;
                  r_idx   <= '0;
                  r_err   <= f_non_bcd(a) | f_non_bcd(b);
                  r_sum   <= '0;
               end
            end
            S_RUN: begin
               for (int d = 0; d < DIGITS; d++)
                  if (r_idx == CNT_W'(d)) r_sum[4*d +: 4] <= w_digit;
               r_carry <= w_carry_nxt;
               r_idx   <= r_idx + CNT_W'(1);
               if (w_last) r_cout <= w_carry_nxt;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Self-checking bench for bcd_serial_add_ctrl: decimal reference model feeding a
// result queue, one task per scenario.
module tb_bcd_serial_add_ctrl;
   localparam int DIGITS = 4;
   localparam int W      = 4*DIGITS;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         err;
   logic         busy;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         err;
   } res_t;

   res_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   bcd_serial_add_ctrl #(.DIGITS(DIGITS), .CNT_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .err(err), .busy(busy)
   );

   always #5 clk = ~clk;

   // Reference works in plain decimal integers rather than per-digit correction.
   function automatic res_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
      res_t r;
      int va, vb, tot, p;
      logic [W-1:0] ta, tb;
      va = 0; vb = 0; p = 1; ta = av; tb = bv;
      r.err = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (ta[3:0] > 4'd9 || tb[3:0] > 4'd9) r.err = 1'b1;
         va = va + int'(ta[3:0]) * p;
         vb = vb + int'(tb[3:0]) * p;
         p  = p * 10;
         ta = ta >> 4;
         tb = tb >> 4;
      end
      tot    = va + vb + int'(cv);
      r.cout = (tot >= p);
      tot    = tot % p;
      r.sum  = '0;
      for (int i = 0; i < DIGITS; i++) begin
         r.sum[4*i +: 4] = 4'(tot % 10);
         tot = tot / 10;
      end
      return r;
   endfunction

   task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
      @(negedge clk);
      in_valid = 1'b1;
      a = av; b = bv; cin = cv;
      sb_q.push_back(model(av, bv, cv));
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Counts negedges (and busy negedges) until out_valid; 99 marks a timeout.
   task automatic wait_done(output int n_neg, output int n_busy);
      n_neg = 0; n_busy = 0;
      while (1) begin
         @(negedge clk);
         n_neg++;
         if (busy) n_busy++;
         if (out_valid) break;
         if (n_neg > 30) begin
            n_neg = 99;
            break;
         end
      end
   endtask

   task automatic consume();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_checks++;
      if ({in_ready, out_valid, busy} !== 3'b100) begin
         n_errors++;
         $display("FAIL reset_ctrl: got rdy/vld/busy=%b want 100", {in_ready, out_valid, busy});
      end
      n_checks++;
      if ({sum, cout, err} !== {16'h0000, 1'b0, 1'b0}) begin
         n_errors++;
         $display("FAIL reset_data: got sum=%h cout=%b err=%b want 0000 0 0", sum, cout, err);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      logic [W-1:0] ta[8];
      logic [W-1:0] tbv[8];
      logic         tc[8];
      int           n, nb;
      res_t         e;
      ta[0] = 16'h1234; tbv[0] = 16'h5678; tc[0] = 1'b0;
      ta[1] = 16'h9999; tbv[1] = 16'h0001; tc[1] = 1'b0;
      ta[2] = 16'h9999; tbv[2] = 16'h9999; tc[2] = 1'b1;
      ta[3] = 16'h0000; tbv[3] = 16'h0000; tc[3] = 1'b0;
      for (int i = 4; i < 8; i++) begin
         for (int d = 0; d < DIGITS; d++) begin
            ta[i][4*d +: 4]  = 4'($urandom_range(0, 9));
            tbv[i][4*d +: 4] = 4'($urandom_range(0, 9));
         end
         tc[i] = 1'($urandom_range(0, 1));
      end
      for (int i = 0; i < 8; i++) begin
         issue(ta[i], tbv[i], tc[i]);
         wait_done(n, nb);
         n_checks++;
         if (n !== DIGITS + 1 || nb !== DIGITS) begin
            n_errors++;
            $display("FAIL basic_latency[%0d]: got negedges=%0d busy=%0d want %0d %0d", i, n, nb, DIGITS + 1, DIGITS);
         end
         e = sb_q.pop_front();
         n_checks++;
         if ({sum, cout, err} !== {e.sum, e.cout, e.err}) begin
            n_errors++;
            $display("FAIL basic_result[%0d]: %h+%h+%b got sum=%h cout=%b err=%b want %h %b %b",
                     i, ta[i], tbv[i], tc[i], sum, cout, err, e.sum, e.cout, e.err);
         end
         consume();
         n_checks++;
         if ({out_valid, in_ready} !== 2'b01) begin
            n_errors++;
            $display("FAIL basic_release[%0d]: got vld/rdy=%b want 01", i, {out_valid, in_ready});
         end
         n_checks++;
         if (sum !== e.sum) begin
            n_errors++;
            $display("FAIL basic_hold[%0d]: got sum=%h want %h", i, sum, e.sum);
         end
      end
   endtask

   task automatic test_ripple();
      res_t e;
      int   nb;
      issue(16'h0999, 16'h0000, 1'b1);
      nb = 0;
      for (int i = 1; i <= DIGITS; i++) begin
         @(negedge clk);
         if (busy) nb++;
         n_checks++;
         if (sum !== 16'h0000 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL ripple_step[%0d]: got sum=%h vld=%b want 0000 0", i, sum, out_valid);
         end
      end
      @(negedge clk);
      e = sb_q.pop_front();
      n_checks++;
      if (nb !== DIGITS || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL ripple_busy: got busy cycles=%0d busy_now=%b want %0d 0", nb, busy, DIGITS);
      end
      n_checks++;
      if ({out_valid, sum, cout} !== {1'b1, e.sum, e.cout} || e.sum !== 16'h1000) begin
         n_errors++;
         $display("FAIL ripple_result: got vld=%b sum=%h cout=%b want 1 1000 0", out_valid, sum, cout);
      end
      consume();
   endtask

   task automatic test_err();
      int   n, nb;
      res_t e;
      issue(16'h12A4, 16'h0000, 1'b0);
      wait_done(n, nb);
      e = sb_q.pop_front();
      n_checks++;
      if ({out_valid, err} !== {1'b1, e.err} || e.err !== 1'b1) begin
         n_errors++;
         $display("FAIL err_flag: got vld=%b err=%b want 1 1", out_valid, err);
      end
      consume();
      issue(16'h0005, 16'h0005, 1'b0);
      wait_done(n, nb);
      e = sb_q.pop_front();
      n_checks++;
      if ({out_valid, err, sum, cout} !== {1'b1, e.err, e.sum, e.cout}) begin
         n_errors++;
         $display("FAIL err_clear: got vld=%b err=%b sum=%h cout=%b want 1 %b %h %b",
                  out_valid, err, sum, cout, e.err, e.sum, e.cout);
      end
      consume();
   endtask

   task automatic test_backpressure();
      int   n, nb;
      res_t e;
      issue(16'h0001, 16'h0002, 1'b0);
      wait_done(n, nb);
      e = sb_q.pop_front();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid = i[0];
         a = 16'h4444; b = 16'h1111; cin = 1'b0;
         n_checks++;
         if ({out_valid, in_ready, busy, sum, cout} !== {3'b100, e.sum, e.cout}) begin
            n_errors++;
            $display("FAIL bp_hold[%0d]: got vld/rdy/busy=%b sum=%h cout=%b want 100 %h %b",
                     i, {out_valid, in_ready, busy}, sum, cout, e.sum, e.cout);
         end
      end
      @(negedge clk);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      sb_q.push_back(model(16'h4444, 16'h1111, 1'b0));
      @(posedge clk);
      #1 out_ready = 1'b0;
      n_checks++;
      if ({out_valid, in_ready, busy} !== 3'b010) begin
         n_errors++;
         $display("FAIL bp_release: got vld/rdy/busy=%b want 010", {out_valid, in_ready, busy});
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      n_checks++;
      if ({in_ready, busy} !== 2'b01) begin
         n_errors++;
         $display("FAIL bp_accept: got rdy/busy=%b want 01", {in_ready, busy});
      end
      wait_done(n, nb);
      e = sb_q.pop_front();
      n_checks++;
      if (n !== DIGITS + 1 || {sum, cout} !== {e.sum, e.cout}) begin
         n_errors++;
         $display("FAIL bp_result: got n=%0d sum=%h cout=%b want %0d %h %b", n, sum, cout, DIGITS + 1, e.sum, e.cout);
      end
      consume();
   endtask

   task automatic test_reset_mid();
      int   n, nb;
      res_t e;
      issue(16'h1111, 16'h2222, 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      e = sb_q.pop_front();
      #1;
      n_checks++;
      if ({out_valid, busy, in_ready, sum} !== {3'b001, 16'h0000}) begin
         n_errors++;
         $display("FAIL midrst_state: got vld/busy/rdy=%b sum=%h want 001 0000", {out_valid, busy, in_ready}, sum);
      end
      @(negedge clk);
      rst_n = 1'b1;
      issue(16'h2345, 16'h4567, 1'b1);
      wait_done(n, nb);
      e = sb_q.pop_front();
      n_checks++;
      if (n !== DIGITS + 1 || {sum, cout, err} !== {e.sum, e.cout, e.err} || e.sum !== 16'h6913) begin
         n_errors++;
         $display("FAIL midrst_after: got n=%0d sum=%h cout=%b err=%b want %0d 6913 0 0", n, sum, cout, err, DIGITS + 1);
      end
      consume();
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; cin = 1'b0;
      test_reset();
      test_basic();
      test_ripple();
      test_err();
      test_backpressure();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
